// File: rtl/uart_serializer_if.sv
// ============================================================================
// Module   : uart_serializer_if
// Purpose  : Byte valid/ready handshake between a byte source and the UART
//            serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface uart_serializer_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input  data_ready);
    modport slave  (input  data_in, input  data_valid, output data_ready);
endinterface

`default_nettype wire

// File: rtl/uart_serializer.sv
// ============================================================================
// Module   : uart_serializer
// Purpose  : Byte-to-line UART transmitter, 8N1 with a 4-bit baud select.
//            Define UART_SERIALIZER_PARITY_EN to insert an even parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_serializer #(
    parameter int CLK_FREQ = 60000000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    uart_serializer_if.slave bus,
    input  wire logic [3:0]  mode,
    output logic             tx_line,
    output logic             busy
);

    localparam int c_DIV_MAX = CLK_FREQ / 9600;
    localparam int c_CNT_W   = (c_DIV_MAX > 1) ? $clog2(c_DIV_MAX) : 1;

    // Divisors are held as DIV-1 so the largest one always fits c_CNT_W.
    localparam int c_D0 = (CLK_FREQ / 9600   > 0) ? CLK_FREQ / 9600   - 1 : 0;
    localparam int c_D1 = (CLK_FREQ / 19200  > 0) ? CLK_FREQ / 19200  - 1 : 0;
    localparam int c_D2 = (CLK_FREQ / 38400  > 0) ? CLK_FREQ / 38400  - 1 : 0;
    localparam int c_D3 = (CLK_FREQ / 57600  > 0) ? CLK_FREQ / 57600  - 1 : 0;
    localparam int c_D4 = (CLK_FREQ / 115200 > 0) ? CLK_FREQ / 115200 - 1 : 0;

    localparam logic [c_CNT_W-1:0] c_DIV0_M1 = c_CNT_W'(c_D0);
    localparam logic [c_CNT_W-1:0] c_DIV1_M1 = c_CNT_W'(c_D1);
    localparam logic [c_CNT_W-1:0] c_DIV2_M1 = c_CNT_W'(c_D2);
    localparam logic [c_CNT_W-1:0] c_DIV3_M1 = c_CNT_W'(c_D3);
    localparam logic [c_CNT_W-1:0] c_DIV4_M1 = c_CNT_W'(c_D4);

`ifdef UART_SERIALIZER_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
    } state_t;
`endif

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [c_CNT_W-1:0]   r_div_m1, w_div_nxt;
    logic [2:0]           r_bit, w_bit_nxt;
    logic [7:0]           r_shift, w_shift_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 w_bit_end;
    logic                 w_accept;
`ifdef UART_SERIALIZER_PARITY_EN
    logic                 r_par, w_par_nxt;
`endif

    function automatic logic [c_CNT_W-1:0] div_m1(input logic [3:0] m);
        case (m)
            4'd0:    div_m1 = c_DIV0_M1;
            4'd1:    div_m1 = c_DIV1_M1;
            4'd2:    div_m1 = c_DIV2_M1;
            4'd3:    div_m1 = c_DIV3_M1;
            default: div_m1 = c_DIV4_M1;
        endcase
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div_m1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_bit_end   = (r_cnt == r_div_m1);
        w_accept    = bus.data_valid & r_ready;
`ifdef UART_SERIALIZER_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = bus.data_in;
                    w_div_nxt   = div_m1(mode);
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
`ifdef UART_SERIALIZER_PARITY_EN
                    w_par_nxt   = ^bus.data_in;
`endif
                end
            end
            S_START: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef UART_SERIALIZER_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_SERIALIZER_PARITY_EN
            S_PARITY: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Outputs are decoded from the next state so every pin is a flop.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
`ifdef UART_SERIALIZER_PARITY_EN
            S_PARITY: w_tx_nxt = w_par_nxt;
`endif
            default: w_tx_nxt = 1'b1;
        endcase
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_div_m1 <= c_DIV0_M1;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef UART_SERIALIZER_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_div_m1 <= w_div_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_tx     <= w_tx_nxt;
            r_ready  <= w_ready_nxt;
            r_busy   <= w_busy_nxt;
`ifdef UART_SERIALIZER_PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

    assign bus.data_ready = r_ready;
    assign tx_line        = r_tx;
    assign busy           = r_busy;

endmodule

`default_nettype wire
